// File: rtl/mod_n_updown_counter_if.sv
// Control/status bundle for the modulo-N up/down counter.
// Every control input is sampled on each rising clk edge; there is no valid/ready
// handshake. The status outputs describe the result of the most recent edge.
interface mod_n_updown_counter_if #(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 2
);
  logic              en;
  logic              load;
  logic              up_down;
  logic              sat_mode;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  din;
  logic [WIDTH-1:0]  dout;
  logic              tc;
  logic              wrap;
  logic              sat_hit;
  logic              load_err;

  modport master (
    output en, load, up_down, sat_mode, step, din,
    input  dout, tc, wrap, sat_hit, load_err
  );

  modport slave (
    input  en, load, up_down, sat_mode, step, din,
    output dout, tc, wrap, sat_hit, load_err
  );
endinterface

// File: rtl/mod_n_updown_counter.sv
// Loadable modulo-N up/down counter with programmable step, wrap/saturate mode
// and one-cycle wrap / clamp / load-error status pulses.
module mod_n_updown_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 12,
  parameter int STEP_W  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  mod_n_updown_counter_if.slave    bus
);

  localparam logic [WIDTH:0] MOD_X = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0] MAX_X = (WIDTH+1)'(MODULUS - 1);

  logic [WIDTH-1:0] dout_q, dout_d;
  logic             wrap_q, wrap_d;
  logic             sat_hit_q, sat_hit_d;
  logic             load_err_q, load_err_d;

  // One extra bit so sums and borrows never overflow before the range test.
  logic [WIDTH:0] cnt_x, step_x, din_x;
  logic [WIDTH:0] sum_x, diff_x, up_wrap_x, dn_wrap_x;
  logic [WIDTH:0] next_x;
  logic           unused_next_msb;

  assign cnt_x     = {1'b0, dout_q};
  assign step_x    = (WIDTH+1)'(bus.step);
  assign din_x     = {1'b0, bus.din};
  assign sum_x     = cnt_x + step_x;
  assign diff_x    = cnt_x - step_x;
  assign up_wrap_x = sum_x - MOD_X;
  assign dn_wrap_x = cnt_x + MOD_X - step_x;

  always_comb begin
    next_x     = cnt_x;
    wrap_d     = 1'b0;
    sat_hit_d  = 1'b0;
    load_err_d = 1'b0;
    if (bus.load) begin
      if (din_x < MOD_X) begin
        next_x = din_x;
      end else begin
        next_x     = MAX_X;
        load_err_d = 1'b1;
      end
    end else if (bus.en && (bus.step != '0)) begin
      if (bus.up_down) begin
        if (sum_x > MAX_X) begin
          if (bus.sat_mode) begin
            next_x    = MAX_X;
            sat_hit_d = 1'b1;
          end else begin
            next_x = up_wrap_x;
            wrap_d = 1'b1;
          end
        end else begin
          next_x = sum_x;
        end
      end else begin
        if (cnt_x < step_x) begin
          if (bus.sat_mode) begin
            next_x    = '0;
            sat_hit_d = 1'b1;
          end else begin
            next_x = dn_wrap_x;
            wrap_d = 1'b1;
          end
        end else begin
          next_x = diff_x;
        end
      end
    end
  end

  // Every branch above yields a value below MODULUS, so the top bit is always 0.
  assign dout_d          = next_x[WIDTH-1:0];
  assign unused_next_msb = next_x[WIDTH];

  always_ff @(posedge clk) begin
    if (!rst) begin
      dout_q     <= '0;
      wrap_q     <= 1'b0;
      sat_hit_q  <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      dout_q     <= dout_d;
      wrap_q     <= wrap_d;
      sat_hit_q  <= sat_hit_d;
      load_err_q <= load_err_d;
    end
  end

  assign bus.dout     = dout_q;
  assign bus.wrap     = wrap_q;
  assign bus.sat_hit  = sat_hit_q;
  assign bus.load_err = load_err_q;
  assign bus.tc       = bus.up_down ? (cnt_x == MAX_X) : (dout_q == '0);

endmodule

// File: doc/mod_n_updown_counter.md
Name: mod_n_updown_counter

Overview:
Parametrised, loadable, modulo-N up/down counter. It is the generalised successor of the team's fixed mod-12 loadable up/down counter. Over that block it adds:
- configurable width and modulus
- programmable step size
- a count enable
- runtime wrap/saturate mode
- terminal-count, wrap, saturation and load-error status

It sits in the same counter/timer verification environment and is driven and monitored through the same driver / write-monitor / read-monitor split.

Parameters:
- WIDTH, 4: counter and din/dout width in bits.
- MODULUS, 12: count range 0..MODULUS-1. Legal range 2 <= MODULUS <= 2**WIDTH.
- STEP_W, 2: width of step input. Requires 2**STEP_W-1 < MODULUS.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  synchronous, active-low reset (0 = reset), sampled on posedge clk.
- en  input  1  count enable.
- load  input  1  synchronous load of din.
- up_down  input  1  1 = count up, 0 = count down.
- sat_mode  input  1  0 = wrap at boundaries, 1 = saturate at boundaries.
- step  input  STEP_W  increment/decrement amount per enabled cycle.
- din  input  WIDTH  load value.
- dout  output  WIDTH  registered count.
- tc  output  1  combinational terminal count.
- wrap  output  1  registered one-cycle pulse: last update wrapped.
- sat_hit  output  1  registered one-cycle pulse: last update was clamped.
- load_err  output  1  registered one-cycle pulse: last load was out of range.

Behaviour:
- Reset:
  - Reset is synchronous and active-low: rst=0 at a posedge clk gives dout=0, wrap=0, sat_hit=0, load_err=0.
  - Reset overrides load and en.
  - Reset mid-count takes effect at the next edge; there is no asynchronous path.
- Priority per edge: rst > load > (en && step!=0) > hold.
- Load:
  - load=1 sets dout <= din when din < MODULUS.
  - If din >= MODULUS: dout <= MODULUS-1 and load_err=1 for one cycle.
  - Load ignores en, step and up_down. wrap and sat_hit are 0 in a load cycle.
- Count: en=1, load=0, step=s != 0; arithmetic is done at WIDTH+1 bits (no intermediate overflow).
  - Up, wrap mode (sat_mode=0):
    - If dout+s >= MODULUS: dout <= dout+s-MODULUS, wrap=1.
    - Else: dout <= dout+s.
  - Down, wrap mode:
    - If dout < s: dout <= dout+MODULUS-s, wrap=1.
    - Else: dout <= dout-s.
  - Up, sat mode: if dout+s > MODULUS-1, dout <= MODULUS-1 and sat_hit=1.
  - Down, sat mode: if dout < s, dout <= 0 and sat_hit=1.
  - sat_hit is asserted every enabled cycle that clamps, including when dout is already at the limit.
  - Exact landing on the limit (e.g. dout+s == MODULUS-1) is not a clamp: sat_hit=0.
- Hold: en=0 or step=0 gives dout unchanged and all pulses 0.
- Pulse outputs (wrap, sat_hit, load_err) are 0 in every cycle that does not itself produce them. They are never held.
- tc = (up_down && dout==MODULUS-1) || (!up_down && dout==0). It is purely combinational from current dout and up_down and is independent of en and sat_mode.
- Mode/direction change: sat_mode and up_down may change any cycle. Each edge uses the values sampled at that edge, with no pipeline state.
- Latency: one cycle from input sampling to dout and pulse update.
- dout is never >= MODULUS after any edge.

Test Plan (WIDTH=4, MODULUS=12, STEP_W=2):
1. Reset:
   - rst=0 for 2 cycles -> dout=0, tc=1 (with up_down=0), all pulses 0.
   - Counting up at dout=7, drive rst=0 one cycle -> dout=0 at that edge, no wrap.
2. Up wrap, step 1:
   - From 0, en=1, up_down=1, step=1 for 11 edges -> dout=11, tc=1, wrap=0.
   - Next edge -> dout=0, wrap=1 for exactly one cycle.
3. Step-3 wrap both directions:
   - dout=10, up, step=3 -> dout=1, wrap=1.
   - Then down, step=3 -> dout=10, wrap=1.
   - dout=3, down, step=3 -> dout=0, wrap=0.
4. Saturate:
   - sat_mode=1, dout=10, up, step=2 -> dout=11, sat_hit=1.
   - Next edge -> dout=11, sat_hit=1.
   - dout=1, down, step=2 -> dout=0, sat_hit=1.
   - dout=9, up, step=2 -> dout=11, sat_hit=0.
5. Load:
   - load=1, en=1, din=5 -> dout=5, no wrap/sat_hit.
   - load=1, din=14 -> dout=11, load_err=1 one cycle.
   - load=1 with rst=0 -> dout=0, load_err=0.
6. Hold:
   - en=0 for 5 cycles at dout=6 -> dout=6, pulses 0.
   - en=1, step=0 -> dout=6, pulses 0.
   - Toggle up_down at dout=0 -> tc follows combinationally (1 down, 0 up).
